// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller at the end of the memory stage.
// Holds SR/Cause/EPC/PRId, raises Req, and services mfc0/mtc0/eret.
module cp0_exc_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic        ExcPrevValid,
  input  logic [4:0]  ExcPrevCode,
  input  logic        ExcAdEL,
  input  logic        ExcAdES,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  excCode;
  logic [31:0] epc;

  logic [4:0]  selCode;
  logic        anyExc;
  logic        intReq;
  logic        excReq;
  logic [31:0] srWord;
  logic [31:0] causeWord;

  // Older stage's exception wins over the memory-stage detector.
  always_comb begin
    if (ExcPrevValid)
      selCode = ExcPrevCode;
    else if (ExcAdEL)
      selCode = 5'd4;
    else
      selCode = 5'd5;
  end

  assign anyExc = ExcPrevValid | ExcAdEL | ExcAdES;
  assign intReq = ie & ~exl & (|(HWInt & im));
  assign excReq = anyExc & ~exl;
  assign Req    = intReq | excReq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ip      <= '0;
      excCode <= '0;
      epc     <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl     <= 1'b1;
        excCode <= intReq ? 5'd0 : selCode;
        bd      <= BDIn;
        epc     <= BDIn ? VPC - 32'd4 : VPC;
      end else begin
        if (EXLClr)
          exl <= 1'b0;
        if (En) begin
          case (CP0Addr)
            5'd12: begin
              im  <= CP0In[15:10];
              exl <= CP0In[1];
              ie  <= CP0In[0];
            end
            5'd14: epc <= CP0In;
            default: ;
          endcase
        end
      end
    end
  end

  assign srWord    = {16'h0, im, 8'h0, exl, ie};
  assign causeWord = {bd, 15'h0, ip, 3'h0, excCode, 2'h0};

  always_comb begin
    case (CP0Addr)
      5'd12:   CP0Out = srWord;
      5'd13:   CP0Out = causeWord;
      5'd14:   CP0Out = epc;
      5'd15:   CP0Out = PRID_VALUE;
      default: CP0Out = 32'h0;
    endcase
  end

  assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed literal checks plus random stimulus
// compared every cycle against a word-level model of SR/Cause/EPC.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h0001_8003;

  logic        clk;
  logic        reset;
  logic        En;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic        ExcPrevValid;
  logic [4:0]  ExcPrevCode;
  logic        ExcAdEL;
  logic        ExcAdES;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;

  int vecs;
  int errs;

  cp0_exc_unit #(.PRID_VALUE(PRID)) dut (
    .clk(clk),
    .reset(reset),
    .En(En),
    .CP0Addr(CP0Addr),
    .CP0In(CP0In),
    .CP0Out(CP0Out),
    .VPC(VPC),
    .BDIn(BDIn),
    .ExcPrevValid(ExcPrevValid),
    .ExcPrevCode(ExcPrevCode),
    .ExcAdEL(ExcAdEL),
    .ExcAdES(ExcAdES),
    .HWInt(HWInt),
    .EXLClr(EXLClr),
    .Req(Req),
    .EPCOut(EPCOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: architectural registers kept as whole 32-bit words.
  logic [31:0] mSR;
  logic [31:0] mCause;
  logic [31:0] mEPC;

  function automatic logic mInt();
    logic [5:0] im;
    im = mSR[15:10];
    return mSR[0] && !mSR[1] && ((HWInt & im) != 6'h0);
  endfunction

  function automatic logic mReq();
    logic exc;
    exc = ExcPrevValid || ExcAdEL || ExcAdES;
    return mInt() || (exc && !mSR[1]);
  endfunction

  function automatic logic [31:0] mCode();
    if (mInt()) return 32'd0;
    if (ExcPrevValid) return {27'h0, ExcPrevCode};
    if (ExcAdEL) return 32'd4;
    return 32'd5;
  endfunction

  function automatic logic [31:0] nextSR();
    logic [31:0] s;
    if (mReq()) return mSR | 32'h2;
    s = mSR;
    if (EXLClr) s = s & ~32'h2;
    if (En && CP0Addr == 5'd12) s = CP0In & 32'h0000_FC03;
    return s;
  endfunction

  function automatic logic [31:0] nextCause();
    logic [31:0] c;
    if (mReq())
      c = (BDIn ? 32'h8000_0000 : 32'h0) + mCode() * 4;
    else
      c = mCause & 32'h8000_007C;
    return c | ({26'h0, HWInt} << 10);
  endfunction

  function automatic logic [31:0] nextEPC();
    if (mReq()) return BDIn ? VPC - 32'd4 : VPC;
    if (En && CP0Addr == 5'd14) return CP0In;
    return mEPC;
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a)
      5'd12:   return mSR;
      5'd13:   return mCause;
      5'd14:   return mEPC;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mSR    <= 32'h0;
      mCause <= 32'h0;
      mEPC   <= 32'h0;
    end else begin
      mSR    <= nextSR();
      mCause <= nextCause();
      mEPC   <= nextEPC();
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model Req", {31'h0, Req}, {31'h0, mReq()});
    chk("model CP0Out", CP0Out, mRead(CP0Addr));
    chk("model EPCOut", EPCOut, mEPC);
  end

  task automatic idle();
    En = 0; CP0Addr = 0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcPrevValid = 0; ExcPrevCode = 0; ExcAdEL = 0; ExcAdES = 0;
    HWInt = 0; EXLClr = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string n, input logic [4:0] a,
                    input logic [31:0] exp);
    CP0Addr = a;
    #1;
    chk(n, CP0Out, exp);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    idle();
    reset = 0;
    HWInt = 6'h3F;
    #2;
    chk("reset Req", {31'h0, Req}, 32'h0);
    rd("reset SR", 12, 32'h0);
    rd("reset Cause", 13, 32'h0);
    rd("reset EPC", 14, 32'h0);
    cyc();
    reset = 1;
    cyc();
    rd("IP latch", 13, 32'h0000_FC00);

    // interrupt taken
    idle();
    En = 1; CP0Addr = 12; CP0In = 32'h0000_0401;
    cyc();
    idle();
    HWInt = 6'h01; VPC = 32'h0000_3010;
    #1 chk("int Req", {31'h0, Req}, 32'h1);
    cyc();
    chk("int EPCOut", EPCOut, 32'h0000_3010);
    rd("int Cause", 13, 32'h0000_0400);
    rd("int SR", 12, 32'h0000_0403);
    chk("int EXL blocks", {31'h0, Req}, 32'h0);

    // AdES in delay slot
    idle(); EXLClr = 1;
    cyc();
    idle();
    ExcAdES = 1; VPC = 32'h0000_3024; BDIn = 1;
    #1 chk("AdES Req", {31'h0, Req}, 32'h1);
    cyc();
    idle();
    rd("AdES EPC", 14, 32'h0000_3020);
    rd("AdES Cause", 13, 32'h8000_0014);

    // earlier-stage code wins
    EXLClr = 1;
    cyc();
    idle();
    ExcPrevValid = 1; ExcPrevCode = 10; ExcAdEL = 1; VPC = 32'h0000_5000;
    cyc();
    idle();
    rd("prev code", 13, 32'h0000_0028);

    // EXL masks, eret, pending interrupt fires
    ExcAdEL = 1; VPC = 32'h0000_6000;
    #1 chk("EXL mask", {31'h0, Req}, 32'h0);
    cyc();
    idle();
    chk("EXL EPC kept", EPCOut, 32'h0000_5000);
    HWInt = 6'h01; EXLClr = 1;
    #1 chk("eret cycle Req", {31'h0, Req}, 32'h0);
    cyc();
    EXLClr = 0;
    rd("eret SR", 12, 32'h0000_0401);
    chk("pending int", {31'h0, Req}, 32'h1);
    cyc();
    idle();
    EXLClr = 1;
    cyc();

    // mtc0 EPC cancelled by exception, then applied
    idle();
    En = 1; CP0Addr = 14; CP0In = 32'h0000_4000;
    ExcAdEL = 1; VPC = 32'h0000_7000;
    #1 chk("mtc0 exc Req", {31'h0, Req}, 32'h1);
    cyc();
    idle();
    chk("mtc0 cancelled", EPCOut, 32'h0000_7000);
    EXLClr = 1;
    cyc();
    idle();
    En = 1; CP0Addr = 14; CP0In = 32'h0000_4000;
    #1 chk("no bypass", EPCOut, 32'h0000_7000);
    cyc();
    idle();
    chk("mtc0 EPC", EPCOut, 32'h0000_4000);
    rd("PRId", 15, PRID);

    // EPC wrap and async reset mid-handler
    ExcAdES = 1; BDIn = 1; VPC = 32'h0000_0002;
    cyc();
    idle();
    chk("EPC wrap", EPCOut, 32'hFFFF_FFFE);
    HWInt = 6'h01;
    #1 reset = 0;
    #1;
    chk("async Req", {31'h0, Req}, 32'h0);
    rd("async SR", 12, 32'h0);
    cyc();
    reset = 1;
    idle();
    cyc();

    for (int i = 0; i < 3000; i++) begin
      En = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: CP0Addr = 5'd12;
        1: CP0Addr = 5'd13;
        2: CP0Addr = 5'd14;
        3: CP0Addr = 5'd15;
        default: CP0Addr = 5'($urandom);
      endcase
      CP0In = $urandom;
      VPC = $urandom;
      BDIn = 1'($urandom);
      ExcPrevValid = ($urandom_range(0, 9) == 0);
      ExcPrevCode = 5'($urandom);
      ExcAdEL = ($urandom_range(0, 11) == 0);
      ExcAdES = ($urandom_range(0, 11) == 0);
      HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
      EXLClr = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 0;
        #1 reset = 1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
